bin_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") on the consumer side of the BCD-to-binary converter. It takes a 10-bit binary value on a start strobe and converts it over BIN_W clocks into packed BCD digits for display or for round-trip checking against the original BCD entry. It completes one conversion at a time, uses a start/busy/done handshake, and holds its result until the next conversion completes.

---
 rtl/bin_bcd_seq_pkg.sv | 12 +
 rtl/bcd_add3.sv | 16 +
 rtl/bin_bcd_seq.sv | 123 ++++++++++++
 tb/tb_bin_bcd_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam int BIN_W_DEF  = 10;
  localparam int DIGITS_DEF = 4;

  typedef logic [3:0] bcd_digit_t;

  // Saturated result: three nines, upper digits zero.
  localparam logic [15:0] SAT_VALUE = 16'h0999;
endpackage

// File: rtl/bcd_add3.sv
// One-digit double-dabble correction: adds 3 when the digit is 5 or more.
module bcd_add3
  import bin_bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  bcd_digit_t sum;

  always_comb begin
    sum = d;
    if (d >= 4'd5) sum = d + 4'd3;
  end

  assign q = sum;
endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional macro BIN_BCD_SAT_EN saturates results above 999 to 0x0999 and raises ovf.
module bin_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  St,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [1:0]            dbg_state
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int CAT_W = BCD_W + BIN_W;

  // Handshake: St is sampled on every edge but only accepted in IDLE or DONE;
  // busy is high for the BIN_W shift cycles; done pulses once when bcd updates.
  state_t             state, state_n;
  logic [BIN_W-1:0]   bin_shift;
  logic [BCD_W-1:0]   bcd_work;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   adj;
  logic [CAT_W-1:0]   cat_n;
  logic [BCD_W-1:0]   res;
  logic [BCD_W-1:0]   bcd_fin;
  logic               ovf_fin;
  logic               load, shift, finish, last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (bcd_work[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  // Adjusted digits and the remaining binary bits shift together as one word.
  assign cat_n = {adj, bin_shift} << 1;
  assign res   = cat_n[CAT_W-1:BIN_W];
  assign last  = (cnt == CNT_W'(BIN_W - 1));

`ifdef BIN_BCD_SAT_EN
  always_comb begin
    bcd_fin = res;
    ovf_fin = 1'b0;
    if (res[BCD_W-1:12] != '0) begin
      bcd_fin = BCD_W'(SAT_VALUE);
      ovf_fin = 1'b1;
    end
  end
`else
  assign bcd_fin = res;
  assign ovf_fin = 1'b0;
`endif

  always_comb begin
    state_n = state;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (St) begin
          state_n = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last) begin
          state_n = DONE;
          finish  = 1'b1;
        end
      end
      DONE: begin
        if (St) begin
          state_n = SHIFT;
          load    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_shift <= '0;
      bcd_work  <= '0;
      cnt       <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        bin_shift <= bin;
        bcd_work  <= '0;
        cnt       <= '0;
      end else if (shift) begin
        bin_shift <= cat_n[BIN_W-1:0];
        bcd_work  <= res;
        cnt       <= cnt + CNT_W'(1);
      end
      if (finish) begin
        bcd <= bcd_fin;
        ovf <= ovf_fin;
      end
    end
  end

  // DONE lasts exactly one cycle, so it doubles as the done pulse.
  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign dbg_state = state;
endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq against a decimal-arithmetic reference model.
// Build with BIN_BCD_SAT_EN defined to check the saturating variant.
module tb_bin_bcd_seq;
  import bin_bcd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        St;
  logic [9:0]  bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  bin_bcd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .St        (St),
    .bin       (bin),
    .bcd       (bcd),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`ifdef BIN_BCD_SAT_EN
    if (v > 999) r = 16'h0999;
`endif
    return r;
  endfunction

  function automatic logic ref_ovf(input int v);
`ifdef BIN_BCD_SAT_EN
    return (v > 999);
`else
    return (v < 0);
`endif
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents St for one edge (the accepting edge E0); returns just after E0.
  task automatic drive_start(input int v);
    St  = 1'b1;
    bin = 10'(v);
    step();
    St  = 1'b0;
    bin = 10'($urandom_range(0, 1023));
  endtask

  // Counts edges until done is seen (bounded); notes whether busy ever dropped.
  task automatic wait_done(output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (!done && cycles < 40) begin
      if (!busy) busy_ok = 1'b0;
      step();
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int c;
    bit bok;
    logic [15:0] e;
    rst_n = 1'b0;
    St    = 1'b1;
    bin   = 10'($urandom_range(0, 1023));
    step();
    step();
    n_cmp++;
    if ({bcd, busy, done, ovf} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got bcd=%h busy=%b done=%b ovf=%b, want 0", bcd, busy, done, ovf);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    St    = 1'b0;
    rst_n = 1'b1;
    step();
    exp_q.push_back(ref_bcd(0));
    drive_start(0);
    wait_done(c, bok);
    e = exp_q.pop_front();
    n_cmp++;
    if (c !== 10 || bcd !== e) begin
      n_err++;
      $display("FAIL zero_conv: got lat=%0d bcd=%h want lat=10 bcd=%h", c, bcd, e);
    end
  endtask

  task automatic test_values();
    int vals[$] = '{227, 629, 982, 999, 1023, 0, 1000, 9};
    int c, v;
    bit bok;
    logic [15:0] e;
    for (int i = 0; i < 8 + 20; i++) begin
      v = (i < 8) ? vals[i] : int'($urandom_range(0, 1023));
      exp_q.push_back(ref_bcd(v));
      drive_start(v);
      wait_done(c, bok);
      e = exp_q.pop_front();
      n_cmp++;
      if (c !== 10) begin
        n_err++;
        $display("FAIL latency bin=%0d: got %0d want 10", v, c);
      end
      n_cmp++;
      if (!bok || busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_window bin=%0d: got busy_ok=%b busy_at_done=%b want 1/0", v, bok, busy);
      end
      n_cmp++;
      if (bcd !== e || ovf !== ref_ovf(v)) begin
        n_err++;
        $display("FAIL result bin=%0d: got bcd=%h ovf=%b want bcd=%h ovf=%b", v, bcd, ovf, e, ref_ovf(v));
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || bcd !== e) begin
        n_err++;
        $display("FAIL done_pulse/hold bin=%0d: got done=%b bcd=%h want 0/%h", v, done, bcd, e);
      end
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic test_ignore_st();
    int c, extra;
    bit bok;
    logic [15:0] e;
    exp_q.push_back(ref_bcd(500));
    drive_start(500);
    repeat (3) step();
    St  = 1'b1;
    bin = 10'd331;
    step();
    St  = 1'b0;
    wait_done(c, bok);
    e = exp_q.pop_front();
    n_cmp++;
    if (c + 4 !== 10 || bcd !== e || !bok) begin
      n_err++;
      $display("FAIL ignore_st: got lat=%0d bcd=%h busy_ok=%b want 10/%h/1", c + 4, bcd, bok, e);
    end
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (done) extra++;
    end
    n_cmp++;
    if (extra !== 0 || bcd !== e) begin
      n_err++;
      $display("FAIL ignore_st_single: got extra_done=%0d bcd=%h want 0/%h", extra, bcd, e);
    end
  endtask

  task automatic test_back_to_back();
    int times[$];
    int idle_wait;
    logic [15:0] e;
    e   = ref_bcd(42);
    St  = 1'b1;
    bin = 10'd42;
    step();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (done) begin
        times.push_back(cyc);
        n_cmp++;
        if (bcd !== e) begin
          n_err++;
          $display("FAIL b2b_value cyc=%0d: got %h want %h", cyc, bcd, e);
        end
      end
    end
    n_cmp++;
    if (times.size() !== 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d want 3", times.size());
    end else begin
      n_cmp++;
      if (times[0] !== 10 || times[1] !== 21 || times[2] !== 32) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d,%0d,%0d want 10,21,32", times[0], times[1], times[2]);
      end
    end
    St = 1'b0;
    idle_wait = 0;
    while ((busy || done) && idle_wait < 30) begin
      step();
      idle_wait++;
    end
    n_cmp++;
    if (busy !== 1'b0 || bcd !== e) begin
      n_err++;
      $display("FAIL b2b_drain: got busy=%b bcd=%h want 0/%h", busy, bcd, e);
    end
  endtask

  task automatic test_reset_abort();
    int c, extra, v;
    bit bok;
    logic [15:0] e;
    drive_start(777);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({bcd, busy, done, ovf} !== 19'd0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL abort: got bcd=%h busy=%b done=%b ovf=%b state=%0d want all 0", bcd, busy, done, ovf, dbg_state);
    end
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0 || bcd !== 16'h0000) begin
      n_err++;
      $display("FAIL abort_quiet: got activity=%0d bcd=%h want 0/0000", extra, bcd);
    end
    v = int'($urandom_range(100, 1023));
    exp_q.push_back(ref_bcd(v));
    drive_start(v);
    wait_done(c, bok);
    e = exp_q.pop_front();
    n_cmp++;
    if (c !== 10 || bcd !== e || ovf !== ref_ovf(v)) begin
      n_err++;
      $display("FAIL after_abort bin=%0d: got lat=%0d bcd=%h ovf=%b want 10/%h/%b", v, c, bcd, ovf, e, ref_ovf(v));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    St    = 1'b0;
    bin   = '0;
    #1;
    test_reset();
    test_values();
    test_ignore_st();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
